sram_stream_reader: RTL
=======================

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 12, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM data and stream width.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first word address; latched on accepted start.
REQ-008 length  input  ADDR_W+1  word count, 0..4096; latched on accepted start.
REQ-009 busy  output  1  high from the accepted start until the cycle done is asserted, inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 address  output  ADDR_W  Avalon-MM master address to the SRAM read port.
REQ-012 chipselect  output  1  read-issue strobe; one word requested per high cycle.
REQ-013 write  output  1  tied 0.
REQ-014 byteenable  output  DATA_W/8  tied all-ones.
REQ-015 readdata  input  DATA_W  SRAM data, valid exactly one cycle after the issuing chipselect cycle.
REQ-016 out_data  output  DATA_W  stream data, taken from the FIFO head.
REQ-017 out_valid  output  1  high when the FIFO is non-empty.
REQ-018 out_ready  input  1  downstream accept; a word transfers when out_valid and out_ready are both high.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-020 IDLE with start=1 and length!=0: latch base_addr and length, go to RUN the next cycle, assert busy.
REQ-021 IDLE with start=1 and length=0: no reads are issued; busy and done are high for exactly the next cycle; return to IDLE.
REQ-022 start SHALL be ignored in RUN and DRAIN.
REQ-023 RUN: issue one read per cycle (chipselect=1, address=current pointer) when (fifo_count + inflight) < FIFO_DEPTH.
REQ-024 Pops in the same cycle do not free credit for that cycle's issue decision.
REQ-025 inflight is 0 or 1; a read issued in cycle N SHALL push readdata into the FIFO in cycle N+1.
REQ-026 The address pointer increments by 1 per issued read, modulo 2^ADDR_W (4095 -> 0 wraps with no error).
REQ-027 When the issued count equals length, deassert chipselect and go to DRAIN the next cycle.
REQ-028 DRAIN: when the FIFO is empty and inflight=0, assert done and busy for one cycle, then go to IDLE.
REQ-029 Simultaneous FIFO push and pop SHALL be legal at any occupancy, including full; count is unchanged.
REQ-030 The FIFO SHALL never overflow; stream order SHALL equal address order.
REQ-031 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 Throughput SHALL be one word per cycle when out_ready is held high.
REQ-033 First-word latency SHALL be: start in cycle 0, first chipselect in cycle 1, out_valid in cycle 3.

Reset
REQ-034 While reset_n=0 at a clock edge: FSM to IDLE; busy, done, chipselect, out_valid = 0; address = 0; FIFO and inflight cleared.
REQ-035 Reset mid-transfer SHALL abort the transfer with no done pulse.
REQ-036 readdata returned in the cycle after reset deasserts SHALL be discarded.

Verification
REQ-037 Preload SRAM[i] = i. Apply base=0x010, length=8, out_ready=1 -> out_data 0x0010..0x0017 consecutively from cycle 3; done in cycle 11; busy low in cycle 12.
REQ-038 base=0xFFE, length=4 -> addresses FFE, FFF, 000, 001 are issued; data in that order.
REQ-039 length=16 with out_ready=0 for 20 cycles -> exactly FIFO_DEPTH (4) reads are issued, then chipselect stays 0; after release all 16 words arrive in order, none lost or duplicated.
REQ-040 Random out_ready (50%) with length=4096 -> 4096 words in address order; one done pulse.
REQ-041 length=0 -> done high for one cycle after start; chipselect never asserts.
REQ-042 reset_n low for 1 cycle during RUN of length=10 -> no done; out_valid=0 after the reset edge; a new start then behaves as in REQ-037.

Source files
------------

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: reads a block of SRAM words over Avalon-MM and streams them out
// through a small FIFO, issuing reads only when the FIFO has room for their data.
module sram_stream_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              push, pop;
  assign write      = 1'b0;
  assign byteenable = '1;
  assign address    = addr_q;
  assign out_valid  = count_q != '0;
  assign out_data   = mem_q[rd_q];
  assign busy       = state_q != IDLE;
  assign push       = inflight_q;
  assign pop        = out_valid && out_ready;
  // Credit counts words already buffered plus the one in flight; same-cycle pops are ignored.
  assign chipselect = state_q == RUN && (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done        = 1'b0;
    inflight_d  = chipselect;
    count_d     = count_q + CW'(push) - CW'(pop);
    wr_d        = wr_q + PW'(push);
    rd_d        = rd_q + PW'(pop);
    mem_d       = mem_q;
    if (push) mem_d[wr_q] = readdata;
    if (state_q == IDLE && start) begin
      addr_d      = base_addr;
      remaining_d = length;
      state_d     = length == '0 ? DRAIN : RUN;
    end else if (state_q == RUN && chipselect) begin
      addr_d      = addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
      state_d     = remaining_q == 1 ? DRAIN : RUN;
    end else if (state_q == DRAIN && count_q == '0 && !inflight_q) begin
      done    = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule
